// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Holds the program counter and runs instruction fetch at the head of the
//   IF stage. It drives the current PC to the sequential adder and to
//   instruction memory, advances on an accepted fetch, and honours stalls.
//   It also applies branch, jump and jr redirects from ID. Redirects use
//   delay-slot semantics: a redirect never cancels the fetch in flight.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   npc_seq             PC+4 from the sequential adder
//   stall               IF/ID cannot take a new instruction
//   br_taken/br_target  taken branch from ID
//   jmp/jmp_target      j/jal from ID
//   jr/jr_target        jr/jalr from ID
//   imem_ready          instruction memory returns data for pc_o
//   pc_o                current fetch PC
//   imem_req            fetch request to instruction memory
//   fetch_valid         instruction for pc_o is available to IF/ID
//   pc_misalign         sticky flag for a misaligned redirect target
//
// Build option
//   PC_ALIGN_CHK_EN  when defined, pc_misalign is set by any selected redirect
//                    whose target has bits [1:0] != 0. When undefined,
//                    pc_misalign is tied low.
//
// State | Meaning
// ------+-----------------------------------------------------------
// IDLE  | first cycle out of reset, nothing requested
// FETCH | request pc_o from imem, wait for imem_ready
// HOLD  | fetched word is waiting on a stalled IF/ID, pc_o frozen

module pc_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] npc_seq,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              jr,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] pc_o,
    output logic              imem_req,
    output logic              fetch_valid,
    output logic              pc_misalign
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));

    state_t            state, state_nxt;
    logic              advance;
    logic              redir;
    logic [ADDR_W-1:0] redir_pc_raw;
    logic [ADDR_W-1:0] redir_pc;
    logic [ADDR_W-1:0] next_pc;
    logic              pend;
    logic [ADDR_W-1:0] pend_pc;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and outputs
    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        fetch_valid = 1'b0;
        advance     = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                imem_req    = 1'b1;
                fetch_valid = imem_ready;
                if (imem_ready) begin
                    if (stall) begin
                        state_nxt = HOLD;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            HOLD: begin
                fetch_valid = 1'b1;
                if (!stall) begin
                    advance   = 1'b1;
                    state_nxt = FETCH;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Redirect select: jr > jmp > branch. The loaded target is always word-aligned.
    always_comb begin
        redir        = jr | jmp | br_taken;
        redir_pc_raw = br_target;
        if (jr) begin
            redir_pc_raw = jr_target;
        end else if (jmp) begin
            redir_pc_raw = jmp_target;
        end
        redir_pc = redir_pc_raw & ALIGN_MASK;
    end

    // A redirect seen in the advancing cycle wins. Otherwise a redirect that
    // was parked while pc_o was frozen wins. Otherwise fetch runs sequentially.
    always_comb begin
        next_pc = npc_seq;
        if (redir) begin
            next_pc = redir_pc;
        end else if (pend) begin
            next_pc = pend_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_o    <= RESET_PC;
            pend    <= 1'b0;
            pend_pc <= '0;
        end else if (advance) begin
            pc_o <= next_pc;
            pend <= 1'b0;
        end else if (redir) begin
            // The newest redirect replaces any earlier one that is still parked.
            pend    <= 1'b1;
            pend_pc <= redir_pc;
        end
    end

`ifdef PC_ALIGN_CHK_EN
    logic misalign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (redir && (redir_pc_raw[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end

    assign pc_misalign = misalign_q;
`else
    assign pc_misalign = 1'b0;
`endif

endmodule
